// File: rtl/apple_video_fetch.sv
// apple_video_fetch
//   Fetches one Apple II scanline (40 bytes, as 20 x 32-bit words) from a
//   shadow memory read port. The words go into a 4-entry first-word-fall-through
//   FIFO that feeds a ready/valid stream.
//
//   Each word takes two cycles. In ISSUE the address is presented. In CAPTURE
//   the address is held, and the read data, which arrives one cycle after the
//   address, is pushed into the FIFO. While the FIFO is full, the fetcher waits
//   in ISSUE with the read request low.
//
// Ports
//   clk_logic        in   1  clock (rising edge)
//   system_reset_n   in   1  asynchronous active-low reset
//   start_i          in   1  one-cycle request to fetch a scanline
//   line_i           in   8  scanline 0..191
//   text_mode_i      in   1  soft switch TEXT
//   hires_mode_i     in   1  soft switch HIRES
//   page2_i          in   1  soft switch PAGE2
//   mixed_i          in   1  soft switch MIXED (used only with the option below)
//   video_address_o  out 16  shadow memory address
//   video_rd_o       out  1  shadow memory read request
//   video_data_i     in  32  shadow memory read data (one-cycle latency)
//   word_o           out 32  stream data (FIFO head)
//   word_valid_o     out  1  stream valid
//   word_ready_i     in   1  stream ready
//   word_last_o      out  1  marks the 20th word of a line
//   busy_o           out  1  high from an accepted start to the last accept
//
// Build option
//   APPLE_VIDEO_FETCH_MIXED_EN : when defined, lines 160-191 use text
//   addressing if mixed_i=1. When undefined, mixed_i is ignored.
`timescale 1ns/1ps

module apple_video_fetch (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        start_i,
  input  logic [7:0]  line_i,
  input  logic        text_mode_i,
  input  logic        hires_mode_i,
  input  logic        page2_i,
  input  logic        mixed_i,
  output logic [15:0] video_address_o,
  output logic        video_rd_o,
  input  logic [31:0] video_data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        word_last_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic [4:0] LAST_WORD = 5'd19;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [4:0]  wcnt_q, wcnt_d;

  logic [32:0] fifo_mem [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        start_ok;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        last_capture;
  logic [32:0] head;

  // ---------------------------------------------------------------------------
  // Base address of the requested line. It is computed from the live inputs
  // and sampled into addr_q only on an accepted start, so that later switch
  // changes do not affect a line that is already being fetched.
  // ---------------------------------------------------------------------------
  logic        mixed_region;
  logic        use_hires;
  logic [15:0] text_base;
  logic [15:0] hires_base;
  logic [15:0] base;
  logic [1:0]  third;   // line/64 == row/8

`ifdef APPLE_VIDEO_FETCH_MIXED_EN
  assign mixed_region = mixed_i && (line_i >= 8'd160);
`else
  logic unused_mixed;
  assign unused_mixed = mixed_i;
  assign mixed_region = 1'b0;
`endif

  assign third     = line_i[7:6];
  assign use_hires = hires_mode_i && !text_mode_i && !mixed_region;

  // 0x28 * third is formed as (third << 5) + (third << 3).
  assign text_base  = (page2_i ? 16'h0800 : 16'h0400)
                    + {6'd0, line_i[5:3], 7'd0}
                    + {9'd0, third, 5'd0} + {11'd0, third, 3'd0};
  assign hires_base = (page2_i ? 16'h4000 : 16'h2000)
                    + {3'd0, line_i[2:0], 10'd0}
                    + {6'd0, line_i[5:3], 7'd0}
                    + {9'd0, third, 5'd0} + {11'd0, third, 3'd0};
  assign base       = use_hires ? hires_base : text_base;

  assign start_ok     = (state_q == IDLE) && start_i && (line_i < 8'd192);
  assign fifo_full    = (cnt_q == 3'd4);
  assign fifo_empty   = (cnt_q == 3'd0);
  assign push         = (state_q == CAPTURE);
  assign pop          = !fifo_empty && word_ready_i;
  assign last_capture = push && (wcnt_q == LAST_WORD);
  assign head         = fifo_mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = ISSUE;
      ISSUE:   if (!fifo_full) state_d = CAPTURE;
      CAPTURE: state_d = (wcnt_q == LAST_WORD) ? DRAIN : ISSUE;
      DRAIN:   if (pop && head[32]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    video_rd_o = 1'b0;
    busy_o     = 1'b1;
    unique case (state_q)
      IDLE:    busy_o     = 1'b0;
      ISSUE:   video_rd_o = !fifo_full;
      CAPTURE: video_rd_o = 1'b1;
      DRAIN:   video_rd_o = 1'b0;
      default: busy_o     = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address and word counter. After a capture, the address advances by two
  // columns, except after the last capture, where it keeps the final address.
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d = addr_q;
    wcnt_d = wcnt_q;
    if (start_ok) begin
      addr_d = base;
      wcnt_d = 5'd0;
    end else if (push) begin
      wcnt_d = wcnt_q + 5'd1;
      if (!last_capture) addr_d = addr_q + 16'd2;
    end
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      addr_q <= 16'd0;
      wcnt_q <= 5'd0;
    end else begin
      addr_q <= addr_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign video_address_o = addr_q;

  // ---------------------------------------------------------------------------
  // Output FIFO: 4 x {last, data}, first-word-fall-through. The fetcher never
  // enters CAPTURE while the FIFO is full, so a push always finds a free entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // The storage has no reset. The outputs below are masked while the FIFO is
  // empty, so stale entries are never visible.
  always_ff @(posedge clk_logic) begin
    if (push) fifo_mem[wr_ptr_q] <= {last_capture, video_data_i};
  end

  assign word_valid_o = !fifo_empty;
  assign word_o       = fifo_empty ? 32'd0 : head[31:0];
  assign word_last_o  = !fifo_empty && head[32];

endmodule

// File: tb/tb_apple_video_fetch.sv
`timescale 1ns/1ps

module tb_apple_video_fetch;

  logic        clk_logic = 1'b0;
  logic        system_reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  line_i = 8'd0;
  logic        text_mode_i = 1'b0;
  logic        hires_mode_i = 1'b0;
  logic        page2_i = 1'b0;
  logic        mixed_i = 1'b0;
  logic [15:0] video_address_o;
  logic        video_rd_o;
  logic [31:0] video_data_i = 32'd0;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b1;
  logic        word_last_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cycles = 0;

  apple_video_fetch dut (
    .clk_logic      (clk_logic),
    .system_reset_n (system_reset_n),
    .start_i        (start_i),
    .line_i         (line_i),
    .text_mode_i    (text_mode_i),
    .hires_mode_i   (hires_mode_i),
    .page2_i        (page2_i),
    .mixed_i        (mixed_i),
    .video_address_o(video_address_o),
    .video_rd_o     (video_rd_o),
    .video_data_i   (video_data_i),
    .word_o         (word_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .word_last_o    (word_last_o),
    .busy_o         (busy_o)
  );

  always #5 clk_logic = ~clk_logic;

  // Shadow memory: returns {~addr, addr} one cycle after the address.
  always @(posedge clk_logic) video_data_i <= {~video_address_o, video_address_o};

  always @(posedge clk_logic) if (video_rd_o) rd_cycles <= rd_cycles + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Accepts 20 words with ready=1 and checks the data,
  // the last flag, the drop of busy one cycle later and the held final address.
  task automatic collect(input string tag, input logic [15:0] base);
    int k = 0;
    int cyc = 0;
    logic [15:0] exp_a;
    while (k < 20 && cyc < 400) begin
      if (word_valid_o && word_ready_i) begin
        exp_a = base + 16'(2 * k);
        chk($sformatf("%s word%0d", tag, k), word_o, {~exp_a, exp_a});
        chk($sformatf("%s last%0d", tag, k), {31'd0, word_last_o}, {31'd0, (k == 19)});
        k++;
      end
      if (k < 20) begin
        @(negedge clk_logic);
        cyc++;
      end
    end
    chk({tag, " word count"}, k, 20);
    @(negedge clk_logic);
    chk({tag, " busy after last"}, {31'd0, busy_o}, 32'd0);
    chk({tag, " valid after last"}, {31'd0, word_valid_o}, 32'd0);
    chk({tag, " rd after last"}, {31'd0, video_rd_o}, 32'd0);
    chk({tag, " addr held"}, {16'd0, video_address_o}, {16'd0, base + 16'd38});
  endtask

  // Called at a negedge: pulses start, scrambles the inputs, then collects.
  task automatic run_line(input string tag, input logic [7:0] ln, input logic t, input logic h,
                          input logic p2, input logic mx, input logic [15:0] base);
    line_i = ln; text_mode_i = t; hires_mode_i = h; page2_i = p2; mixed_i = mx;
    start_i = 1'b1;
    @(negedge clk_logic);
    start_i = 1'b0;
    line_i = ~ln; text_mode_i = ~t; hires_mode_i = ~h; page2_i = ~p2; mixed_i = ~mx;
    chk({tag, " busy"}, {31'd0, busy_o}, 32'd1);
    chk({tag, " rd"}, {31'd0, video_rd_o}, 32'd1);
    chk({tag, " first addr"}, {16'd0, video_address_o}, {16'd0, base});
    collect(tag, base);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " addr"},  {16'd0, video_address_o}, 32'd0);
    chk({tag, " rd"},    {31'd0, video_rd_o}, 32'd0);
    chk({tag, " valid"}, {31'd0, word_valid_o}, 32'd0);
    chk({tag, " last"},  {31'd0, word_last_o}, 32'd0);
    chk({tag, " busy"},  {31'd0, busy_o}, 32'd0);
    chk({tag, " word"},  word_o, 32'd0);
  endtask

  initial begin
    int r0;
    int k;
    int cyc;
    repeat (3) @(negedge clk_logic);
    chk_reset_outputs("reset");

    // The start coincides with the first rising edge after release.
    system_reset_n = 1'b1;
    run_line("txt p1 l0", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0400);

    // An out-of-range line is ignored.
    @(negedge clk_logic);
    line_i = 8'd200; text_mode_i = 1'b1; start_i = 1'b1;
    @(negedge clk_logic);
    start_i = 1'b0;
    chk("bad line busy", {31'd0, busy_o}, 32'd0);
    chk("bad line rd", {31'd0, video_rd_o}, 32'd0);

    run_line("txt p2 l64", 8'd64, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0828);
    run_line("hgr p1 l1", 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2400);
    run_line("hgr p1 l191", 8'd191, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3FD0);
    run_line("lores p1 l8", 8'd8, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0480);
    // Line 160 hires = 0x2000 + 0x80*4 + 0x28*2; as text row 20 = 0x0400 + 0x80*4 + 0x28*2.
`ifdef APPLE_VIDEO_FETCH_MIXED_EN
    run_line("mixed l160", 8'd160, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0650);
`else
    run_line("mixed l160", 8'd160, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2250);
`endif
    // Line 159 is above the mixed region: 0x2000 + 0x1C00 + 0x180 + 0x50.
    run_line("mixed l159", 8'd159, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3DD0);

    // Backpressure: exactly four captures (8 read cycles), then a stall.
    @(negedge clk_logic);
    word_ready_i = 1'b0;
    line_i = 8'd0; text_mode_i = 1'b1; hires_mode_i = 1'b0; page2_i = 1'b0; mixed_i = 1'b0;
    r0 = rd_cycles;
    start_i = 1'b1;
    @(negedge clk_logic);
    start_i = 1'b0;
    repeat (20) @(negedge clk_logic);
    chk("bp rd cycles", rd_cycles - r0, 8);
    chk("bp rd low", {31'd0, video_rd_o}, 32'd0);
    chk("bp addr", {16'd0, video_address_o}, 32'h0408);
    repeat (5) @(negedge clk_logic);
    chk("bp addr frozen", {16'd0, video_address_o}, 32'h0408);
    chk("bp rd cycles frozen", rd_cycles - r0, 8);
    chk("bp valid", {31'd0, word_valid_o}, 32'd1);
    chk("bp head", word_o, {~16'h0400, 16'h0400});
    word_ready_i = 1'b1;
    collect("bp resume", 16'h0400);

    // Reset in the middle of a line.
    @(negedge clk_logic);
    line_i = 8'd0; text_mode_i = 1'b1; hires_mode_i = 1'b0; page2_i = 1'b0;
    start_i = 1'b1;
    @(negedge clk_logic);
    start_i = 1'b0;
    k = 0; cyc = 0;
    while (k < 10 && cyc < 200) begin
      if (word_valid_o && word_ready_i) k++;
      if (k < 10) begin
        @(negedge clk_logic);
        cyc++;
      end
    end
    chk("midreset reached word 10", k, 10);
    system_reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk_logic);
    system_reset_n = 1'b1;
    chk("midreset valid after release", {31'd0, word_valid_o}, 32'd0);
    run_line("after reset l8", 8'd8, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0480);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
